// File: rtl/fp32_to_int_seq.sv
// Serial IEEE-754 single to signed OUT_W-bit integer converter.
// Round to nearest, ties away from zero; one shifter bit per cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for an input word, in_ready high
// CLASSIFY | decode specials, pick shift direction and count N
// SHIFT    | shift magnitude one bit per cycle until the counter hits 1
// ROUND    | add guard, apply sign, detect overflow, register result
// DONE     | present result until the consumer accepts it
module fp32_to_int_seq #(
    parameter int OUT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_nan
);
    typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, ROUND, DONE} state_t;

    localparam int AW = 33;
    localparam logic [AW-1:0] KEEP_MASK = (AW'(1) << OUT_W) - AW'(1);
    localparam logic [AW-1:0] LIM_POS   = (AW'(1) << (OUT_W - 1)) - AW'(1);
    localparam logic [AW-1:0] LIM_NEG   = AW'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [9:0] E_TOP = 10'(22 + OUT_W);
    localparam logic signed [9:0] E_OVF = 10'(OUT_W - 1);

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [7:0]        exp_q, exp_d;
    logic [23:0]       mant_q, mant_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              left_q, left_d;
    logic              ovf_q, ovf_d;
    logic              nan_q, nan_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_nan_q, out_nan_d;
    logic              out_valid_q, out_valid_d;

    logic signed [9:0] e_s;
    logic              frac_nz;
    logic [4:0]        n_right, n_left;
    logic              cls_nan, cls_ovf, cls_zero, cls_left;
    logic [4:0]        cls_n;
    logic [AW-1:0]     mag_rnd;
    logic [OUT_W-1:0]  mag_lo, sval;
    logic              rnd_ovf, res_ovf;

    assign e_s     = $signed({2'b00, exp_q}) - 10'sd127;
    assign frac_nz = |mant_q[22:0];
    assign n_right = 5'd23 - e_s[4:0];
    assign n_left  = e_s[4:0] - 5'd23;

    always_comb begin
        cls_nan  = 1'b0;
        cls_ovf  = 1'b0;
        cls_zero = 1'b0;
        cls_left = 1'b0;
        cls_n    = 5'd0;
        if (exp_q == 8'hFF) begin
            cls_nan  = frac_nz;
            cls_ovf  = !frac_nz;
            cls_zero = 1'b1;
        end else if (exp_q == 8'h00 || e_s < -10'sd1) begin
            cls_zero = 1'b1;
        end else if (e_s <= 10'sd22) begin
            cls_n = n_right;
        end else if (e_s <= E_TOP) begin
            cls_left = 1'b1;
            cls_n    = n_left;
        end else begin
            cls_ovf  = 1'b1;
            cls_zero = 1'b1;
        end
        // -2^(OUT_W-1) exactly is the one in-range value with e = OUT_W-1
        if (!cls_zero && e_s >= E_OVF && !(sign_q && !frac_nz && e_s == E_OVF))
            cls_ovf = 1'b1;
    end

    assign mag_rnd = acc_q + {{(AW-1){1'b0}}, guard_q};
    assign mag_lo  = mag_rnd[OUT_W-1:0];
    assign sval    = sign_q ? -mag_lo : mag_lo;
    assign rnd_ovf = sign_q ? (mag_rnd > LIM_NEG) : (mag_rnd > LIM_POS);
    assign res_ovf = ovf_q | rnd_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (in_valid) state_d = CLASSIFY;
            CLASSIFY: state_d = (cls_n != 5'd0) ? SHIFT : ROUND;
            SHIFT:    if (cnt_q == 5'd1) state_d = ROUND;
            ROUND:    state_d = DONE;
            DONE:     if (out_valid_q && out_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    out_valid_d = !(out_valid_q && out_ready);
            default: ;
        endcase
    end

    always_comb begin
        sign_d     = sign_q;
        exp_d      = exp_q;
        mant_d     = mant_q;
        acc_d      = acc_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        ovf_d      = ovf_q;
        nan_d      = nan_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        out_nan_d  = out_nan_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d = in_data[31];
                exp_d  = in_data[30:23];
                mant_d = {|in_data[30:23], in_data[22:0]};
            end
            CLASSIFY: begin
                acc_d    = cls_zero ? '0 : {{(AW-24){1'b0}}, mant_q};
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                cnt_d    = cls_n;
                left_d   = cls_left;
                ovf_d    = cls_ovf;
                nan_d    = cls_nan;
            end
            SHIFT: begin
                cnt_d = cnt_q - 5'd1;
                if (left_q) begin
                    ovf_d = ovf_q | acc_q[OUT_W-1];
                    acc_d = (acc_q << 1) & KEEP_MASK;
                end else begin
                    acc_d    = acc_q >> 1;
                    guard_d  = acc_q[0];
                    sticky_d = sticky_q | guard_q;
                end
            end
            ROUND: begin
                out_nan_d  = nan_q;
                out_ovf_d  = res_ovf;
                out_data_d = (SATURATE && res_ovf) ? (sign_q ? MIN_VAL : MAX_VAL) : sval;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            acc_q       <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            ovf_q       <= 1'b0;
            nan_q       <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_nan_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            acc_q       <= acc_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            ovf_q       <= ovf_d;
            nan_q       <= nan_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_nan_q   <= out_nan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_nan   = out_nan_q;
endmodule

// File: tb/tb_fp32_to_int_seq.sv
// Bench for fp32_to_int_seq: saturating and wrapping instances driven in lockstep,
// expected results from a real-arithmetic model queued at accept time.
module tb_fp32_to_int_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic        out_ovf0, out_ovf1, out_nan0, out_nan1;
    logic [31:0] out_data0, out_data1;
    logic        fixed_rdy, rand_rdy;

    always #5 clk = ~clk;

    fp32_to_int_seq #(.OUT_W(32), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_ovf(out_ovf0), .out_nan(out_nan0));

    fp32_to_int_seq #(.OUT_W(32), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_ovf(out_ovf1), .out_nan(out_nan1));

    typedef struct {
        logic [31:0] d_sat;
        logic [31:0] d_wrap;
        logic        ovf;
        logic        nan;
        int          lat;
        longint      acc_cyc;
    } exp_t;

    exp_t   sbq[$];
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    bit     active = 0;
    exp_t   cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Value-level model: decode the float, round half away from zero, then clamp or wrap.
    function automatic exp_t model(input logic [31:0] x);
        exp_t   m;
        int     ex, e, mant_i, ex_eff;
        real    rr, mg;
        longint li;
        logic   neg;
        ex  = int'(x[30:23]);
        e   = ex - 127;
        neg = x[31];
        m.nan = 0; m.ovf = 0; m.d_sat = 0; m.d_wrap = 0; m.acc_cyc = 0;
        if (ex == 255 || ex == 0 || e < -1 || e > 54) m.lat = 3;
        else if (e <= 22) m.lat = 3 + 23 - e;
        else m.lat = 3 + e - 23;
        if (ex == 255) begin
            if (x[22:0] != 0) m.nan = 1;
            else begin
                m.ovf   = 1;
                m.d_sat = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
            return m;
        end
        mant_i = (ex == 0) ? int'(x[22:0]) : int'({1'b1, x[22:0]});
        ex_eff = (ex == 0) ? 1 : ex;
        rr = real'(mant_i) * (2.0 ** (ex_eff - 150));
        mg = $floor(rr + 0.5);
        m.ovf = neg ? (mg > 2147483648.0) : (mg > 2147483647.0);
        if (rr >= 4.0e18) li = 0;
        else begin
            li = longint'(mg);
            if (neg) li = -li;
        end
        m.d_wrap = li[31:0];
        m.d_sat  = m.ovf ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : m.d_wrap;
        return m;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
        end
    end

    // Monitor: pops on the first cycle a result is presented, checks it every cycle it is held.
    initial forever begin
        @(negedge clk);
        if (!rst_n) active = 0;
        else if (out_valid0 && !active) begin
            if (sbq.size() == 0) chk("unexpected_valid", {31'b0, out_valid0}, 32'd0);
            else begin
                cur    = sbq.pop_front();
                active = 1;
                chk("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
            end
        end
        if (active && rst_n) begin
            if (!out_valid0) begin
                chk("valid_drop", {31'b0, out_valid0}, 32'd1);
                active = 0;
            end else begin
                chk("sat_data", out_data0, cur.d_sat);
                chk("sat_ovf", {31'b0, out_ovf0}, {31'b0, cur.ovf});
                chk("sat_nan", {31'b0, out_nan0}, {31'b0, cur.nan});
                chk("wrap_valid", {31'b0, out_valid1}, 32'd1);
                chk("wrap_data", out_data1, cur.d_wrap);
                chk("wrap_ovf", {31'b0, out_ovf1}, {31'b0, cur.ovf});
                chk("wrap_nan", {31'b0, out_nan1}, {31'b0, cur.nan});
                if (out_ready) active = 0;
            end
        end
    end

    task automatic send(input logic [31:0] x);
        exp_t m;
        int   n;
        m = model(x);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        n = 0;
        while (in_ready0 !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (in_ready0 !== 1'b1) begin
            chk("send_timeout", {31'b0, in_ready0}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        m.acc_cyc = cyc + 1;
        sbq.push_back(m);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sbq.size() != 0 || active || out_valid0) && n < 2000);
        if (sbq.size() != 0 || active) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    logic [31:0] dir_vec [16] = '{
        32'h400B851F, 32'h511502F9, 32'h3F000000, 32'hC0200000,
        32'h3EFFFFFF, 32'hCF000000, 32'h7FC00000, 32'hFF800000,
        32'h00000001, 32'h7F800000, 32'h00000000, 32'h80000000,
        32'h4F000000, 32'h5F000000, 32'h3FC00000, 32'hBFC00000};

    initial begin
        int          n;
        logic [7:0]  ex;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        fixed_rdy = 1'b1; rand_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready0}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("rst_out_data", out_data0, 32'd0);
        chk("rst_out_ovf", {31'b0, out_ovf0}, 32'd0);
        chk("rst_out_nan", {31'b0, out_nan0}, 32'd0);
        chk("rst_wrap_in_ready", {31'b0, in_ready1}, 32'd1);
        rst_n = 1'b1;

        foreach (dir_vec[i]) begin
            send(dir_vec[i]);
            drain();
        end

        // Backpressure: result must hold and the input side must stay closed.
        fixed_rdy = 1'b0;
        repeat (2) @(negedge clk);
        send(32'h400B851F);
        n = 0;
        while (!out_valid0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", {31'b0, out_valid0}, 32'd1);
        repeat (10) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            chk("bp_in_ready", {31'b0, in_ready0}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        fixed_rdy = 1'b1;
        n = 0;
        while (!(out_valid0 && out_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("bp_release_in_ready", {31'b0, in_ready0}, 32'd1);
        chk("bp_release_valid", {31'b0, out_valid0}, 32'd0);
        drain();

        // Reset in the middle of the shift phase aborts the conversion.
        send(32'h511502F9);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();
        chk("mid_rst_in_ready", {31'b0, in_ready0}, 32'd1);
        chk("mid_rst_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("mid_rst_out_data", out_data0, 32'd0);
        chk("mid_rst_out_ovf", {31'b0, out_ovf0}, 32'd0);
        chk("mid_rst_wrap_data", out_data1, 32'd0);
        send(32'h400B851F);
        drain();

        rand_rdy = 1'b1;
        repeat (300) begin
            ex = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(120, 185));
            send({1'($urandom_range(0, 1)), ex, 23'($urandom)});
        end
        drain();
        rand_rdy = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
